// File: rtl/rotating_xbar_reg.sv
// Registered rotating crossbar: each accepted beat is rotated by a start pointer that
// self-advances up or down by a run-time step, giving round-robin lane spreading at full rate.
module rotating_xbar_reg #(
   parameter  int NUM_DATA   = 4,
   parameter  int DATA_WIDTH = 4,
   localparam int PW         = $clog2(NUM_DATA)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] input_vector_i,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [PW-1:0]                       step_i,
   input  logic                                dir_i,
   input  logic                                load_i,
   input  logic [PW-1:0]                       load_ptr_i,
   output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] output_vector_o,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [PW-1:0]                       ptr_o
);
   localparam logic [PW:0] NUM_W = (PW+1)'(NUM_DATA);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                              state_r;
   state_t                              state_n_s;
   logic [PW-1:0]                       ptr_r;
   logic [PW-1:0]                       ptr_n_s;
   logic [PW-1:0]                       step_mod_s;
   logic [NUM_DATA-1:0][DATA_WIDTH-1:0] rot_s;
   logic [NUM_DATA-1:0][DATA_WIDTH-1:0] out_vec_r;
   logic                                acc_s;
   logic                                pop_s;

   // Every operand fed in here is below 2*NUM_DATA, so one conditional subtract is a full modulo.
   function automatic logic [PW-1:0] mod_n(input logic [PW:0] x);
      logic [PW:0] r;
      if (x >= NUM_W) begin
         r = x - NUM_W;
      end else begin
         r = x;
      end
      return r[PW-1:0];
   endfunction

   assign out_valid_o     = (state_r == FULL);
   assign in_ready_o      = rst_ni & (~out_valid_o | out_ready_i);
   assign acc_s           = in_valid_i & in_ready_o;
   assign pop_s           = out_valid_o & out_ready_i;
   assign output_vector_o = out_vec_r;
   assign ptr_o           = ptr_r;

   // Rotate the incoming lanes by the current (pre-update) start pointer.
   always_comb begin
      rot_s = '0;
      for (int i = 0; i < NUM_DATA; i++) begin
         rot_s[i] = input_vector_i[mod_n({1'b0, ptr_r} + (PW+1)'(i))];
      end
   end

   // Output-valid flag next state.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         EMPTY: begin
            if (acc_s) begin
               state_n_s = FULL;
            end else begin
               state_n_s = EMPTY;
            end
         end
         FULL: begin
            if (acc_s) begin
               state_n_s = FULL;
            end else if (pop_s) begin
               state_n_s = EMPTY;
            end else begin
               state_n_s = FULL;
            end
         end
         default: state_n_s = EMPTY;
      endcase
   end

   // Pointer next state: load beats advance; down-steps add the complement so nothing underflows.
   always_comb begin
      step_mod_s = mod_n({1'b0, step_i});
      ptr_n_s    = ptr_r;
      if (load_i) begin
         ptr_n_s = mod_n({1'b0, load_ptr_i});
      end else if (acc_s && !dir_i) begin
         ptr_n_s = mod_n({1'b0, ptr_r} + {1'b0, step_mod_s});
      end else if (acc_s && dir_i) begin
         ptr_n_s = mod_n({1'b0, ptr_r} + NUM_W - {1'b0, step_mod_s});
      end else begin
         ptr_n_s = ptr_r;
      end
   end

   // State, pointer and output-lane registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r   <= EMPTY;
         ptr_r     <= '0;
         out_vec_r <= '0;
      end else begin
         state_r <= state_n_s;
         ptr_r   <= ptr_n_s;
         if (acc_s) begin
            out_vec_r <= rot_s;
         end
      end
   end

endmodule

// File: tb/tb_rotating_xbar_reg.sv
// Self-checking bench: directed scenarios plus a randomized run against a lane/pointer model,
// on a 4-lane instance and a 3-lane (non-power-of-two) instance.
module tb_rotating_xbar_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   logic [3:0][7:0] a_in, a_out;
   logic            a_in_valid, a_in_ready, a_dir, a_load, a_out_valid, a_out_ready;
   logic [1:0]      a_step, a_load_ptr, a_ptr;

   logic [2:0][7:0] b_in, b_out;
   logic            b_in_valid, b_in_ready, b_dir, b_load, b_out_valid, b_out_ready;
   logic [1:0]      b_step, b_load_ptr, b_ptr;

   always #5 clk = ~clk;

   rotating_xbar_reg #(.NUM_DATA(4), .DATA_WIDTH(8)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .input_vector_i(a_in), .in_valid_i(a_in_valid),
      .in_ready_o(a_in_ready), .step_i(a_step), .dir_i(a_dir), .load_i(a_load),
      .load_ptr_i(a_load_ptr), .output_vector_o(a_out), .out_valid_o(a_out_valid),
      .out_ready_i(a_out_ready), .ptr_o(a_ptr));

   rotating_xbar_reg #(.NUM_DATA(3), .DATA_WIDTH(8)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .input_vector_i(b_in), .in_valid_i(b_in_valid),
      .in_ready_o(b_in_ready), .step_i(b_step), .dir_i(b_dir), .load_i(b_load),
      .load_ptr_i(b_load_ptr), .output_vector_o(b_out), .out_valid_o(b_out_valid),
      .out_ready_i(b_out_ready), .ptr_o(b_ptr));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1; a_in = 32'h33221100;
      tick(); tick();
      tests++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out !== 32'h0 || a_ptr !== 2'd0) begin
         fails++;
         $display("FAIL reset_a: ready=%b valid=%b out=%h ptr=%0d, required 0 0 0 0",
                  a_in_ready, a_out_valid, a_out, a_ptr);
      end
      tests++;
      if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0 || b_out !== 24'h0 || b_ptr !== 2'd0) begin
         fails++;
         $display("FAIL reset_b: ready=%b valid=%b out=%h ptr=%0d, required 0 0 0 0",
                  b_in_ready, b_out_valid, b_out, b_ptr);
      end
      a_in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      tests++;
      if (a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b required 1", a_in_ready);
      end
   endtask

   task automatic test_rotation;
      logic [7:0] exp_lane;
      a_in = 32'h33221100; a_step = 2'd1; a_dir = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            exp_lane = 8'(((k + i) % 4) * 17);
            tests++;
            if (a_out[i] !== exp_lane) begin
               fails++;
               $display("FAIL rotation_lane beat %0d lane %0d: got %h required %h", k, i, a_out[i], exp_lane);
            end
         end
         tests++;
         if (a_ptr !== 2'((k + 1) % 4) || a_out_valid !== 1'b1) begin
            fails++;
            $display("FAIL rotation_ptr beat %0d: ptr=%0d valid=%b required %0d 1", k, a_ptr, a_out_valid, (k + 1) % 4);
         end
      end
      a_in_valid = 1'b0;
      tick();
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rotation_drain: valid=%b required 0", a_out_valid);
      end
   endtask

   task automatic test_backpressure;
      logic [3:0][7:0] beat_a, beat_b;
      beat_a = {$urandom}; beat_b = {$urandom};
      a_in = beat_a; a_in_valid = 1'b1; a_out_ready = 1'b1; a_step = 2'd1; a_dir = 1'b0;
      tick();                          // beat A taken at pointer 1, pointer now 2
      a_in = beat_b; a_out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (a_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready cycle %0d: got %b required 0", c, a_in_ready);
         end
         tick();
         tests++;
         if (a_out_valid !== 1'b1 || a_ptr !== 2'd2) begin
            fails++;
            $display("FAIL bp_hold cycle %0d: valid=%b ptr=%0d required 1 2", c, a_out_valid, a_ptr);
         end
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (a_out[i] !== beat_a[(1 + i) % 4]) begin
               fails++;
               $display("FAIL bp_frozen lane %0d: got %h required %h", i, a_out[i], beat_a[(1 + i) % 4]);
            end
         end
      end
      a_out_ready = 1'b1;
      #1;
      tests++;
      if (a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release_ready: got %b required 1", a_in_ready);
      end
      tick();
      a_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (a_out[i] !== beat_b[(2 + i) % 4]) begin
            fails++;
            $display("FAIL bp_beat_b lane %0d: got %h required %h", i, a_out[i], beat_b[(2 + i) % 4]);
         end
      end
      tests++;
      if (a_out_valid !== 1'b1 || a_ptr !== 2'd3) begin
         fails++;
         $display("FAIL bp_beat_b_state: valid=%b ptr=%0d required 1 3", a_out_valid, a_ptr);
      end
      tick();
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_no_duplicate: valid=%b required 0", a_out_valid);
      end
   endtask

   task automatic test_down;
      logic [3:0][7:0] beat;
      a_load = 1'b1; a_load_ptr = 2'd1; a_in_valid = 1'b0;
      tick();
      a_load = 1'b0;
      tests++;
      if (a_ptr !== 2'd1) begin
         fails++;
         $display("FAIL down_load: ptr=%0d required 1", a_ptr);
      end
      a_dir = 1'b1; a_step = 2'd3; a_out_ready = 1'b1; a_in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         beat = {$urandom};
         a_in = beat;
         tick();
         tests++;
         if (a_out[0] !== beat[k + 1] || a_ptr !== 2'(k + 2)) begin
            fails++;
            $display("FAIL down_beat %0d: lane0=%h ptr=%0d required %h %0d", k, a_out[0], a_ptr, beat[k + 1], k + 2);
         end
      end
      a_in_valid = 1'b0; a_dir = 1'b0;
      tick();
   endtask

   task automatic test_load_collision;
      logic [3:0][7:0] beat;
      beat = {$urandom};
      a_load = 1'b1; a_load_ptr = 2'd2; a_in_valid = 1'b0;
      tick();
      a_load_ptr = 2'd0; a_step = 2'd1; a_dir = 1'b0; a_in = beat; a_in_valid = 1'b1; a_out_ready = 1'b1;
      tick();
      a_load = 1'b0; a_in_valid = 1'b0;
      tests++;
      if (a_ptr !== 2'd0) begin
         fails++;
         $display("FAIL collision_ptr: got %0d required 0", a_ptr);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (a_out[i] !== beat[(2 + i) % 4]) begin
            fails++;
            $display("FAIL collision_lane %0d: got %h required %h", i, a_out[i], beat[(2 + i) % 4]);
         end
      end
      tick();
   endtask

   task automatic test_random;
      logic [3:0][7:0] m_out;
      logic            m_valid, m_ready, acc;
      int              m_ptr;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_out = '0; m_valid = 1'b0; m_ptr = 0;
      for (int c = 0; c < 400; c++) begin
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_out_ready = ($urandom_range(0, 3) != 0);
         a_step      = 2'($urandom);
         a_dir       = 1'($urandom);
         a_load      = ($urandom_range(0, 15) == 0);
         a_load_ptr  = 2'($urandom);
         a_in        = {$urandom};
         #1;
         m_ready = !m_valid || a_out_ready;
         acc     = a_in_valid && m_ready;
         tests++;
         if (a_in_ready !== m_ready) begin
            fails++;
            $display("FAIL rand_ready cycle %0d: got %b required %b", c, a_in_ready, m_ready);
         end
         if (acc) begin
            for (int i = 0; i < 4; i++) m_out[i] = a_in[(m_ptr + i) % 4];
            m_valid = 1'b1;
         end else if (a_out_ready) begin
            m_valid = 1'b0;
         end
         if (a_load) m_ptr = int'(a_load_ptr) % 4;
         else if (acc && a_dir) m_ptr = (m_ptr + 4 - int'(a_step) % 4) % 4;
         else if (acc) m_ptr = (m_ptr + int'(a_step)) % 4;
         tick();
         tests++;
         if (a_out_valid !== m_valid || a_ptr !== 2'(m_ptr) || a_out !== m_out) begin
            fails++;
            $display("FAIL rand_state cycle %0d: valid=%b ptr=%0d out=%h required %b %0d %h",
                     c, a_out_valid, a_ptr, a_out, m_valid, m_ptr, m_out);
         end
      end
      a_in_valid = 1'b0; a_load = 1'b0;
   endtask

   task automatic test_non_pow2;
      logic [2:0][7:0] beat;
      int              p;
      p = 0;
      b_step = 2'd2; b_dir = 1'b0; b_load = 1'b0; b_load_ptr = 2'd0; b_out_ready = 1'b1; b_in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         beat = 24'($urandom);
         b_in = beat;
         tick();
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (b_out[i] !== beat[(p + i) % 3]) begin
               fails++;
               $display("FAIL n3_lane beat %0d lane %0d: got %h required %h", k, i, b_out[i], beat[(p + i) % 3]);
            end
         end
         p = (p + 2) % 3;
         tests++;
         if (b_ptr !== 2'(p)) begin
            fails++;
            $display("FAIL n3_ptr beat %0d: got %0d required %0d", k, b_ptr, p);
         end
      end
      b_in_valid = 1'b0; b_load = 1'b1; b_load_ptr = 2'd3;
      tick();
      b_load = 1'b0;
      tests++;
      if (b_ptr !== 2'd0) begin
         fails++;
         $display("FAIL n3_load3: got %0d required 0", b_ptr);
      end
      b_in = 24'hABCDEF; b_in_valid = 1'b1; b_out_ready = 1'b0;
      tick();
      tests++;
      if (b_out_valid !== 1'b1 || b_ptr !== 2'd2) begin
         fails++;
         $display("FAIL n3_prereset: valid=%b ptr=%0d required 1 2", b_out_valid, b_ptr);
      end
      rst_n = 1'b0;
      tick();
      tests++;
      if (b_out_valid !== 1'b0 || b_out !== 24'h0 || b_ptr !== 2'd0 || b_in_ready !== 1'b0) begin
         fails++;
         $display("FAIL n3_midreset: valid=%b out=%h ptr=%0d ready=%b required 0 0 0 0",
                  b_out_valid, b_out, b_ptr, b_in_ready);
      end
      rst_n = 1'b1; b_in_valid = 1'b0;
      tick();
   endtask

   initial begin
      a_in = '0; a_in_valid = 1'b0; a_step = 2'd0; a_dir = 1'b0; a_load = 1'b0; a_load_ptr = 2'd0; a_out_ready = 1'b0;
      b_in = '0; b_in_valid = 1'b0; b_step = 2'd0; b_dir = 1'b0; b_load = 1'b0; b_load_ptr = 2'd0; b_out_ready = 1'b0;
      test_reset();
      test_rotation();
      test_backpressure();
      test_down();
      test_load_collision();
      test_random();
      test_non_pow2();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
